// File: rtl/logbar_pkg.sv
// Shared types and constants for the log-bar scheduler and the display driver.
package logbar_pkg;
    localparam int BARW        = 7;
    localparam int NBAR_DEF    = 32;
    localparam int DECAY_DEF   = 1;
    localparam int TIMEOUT_DEF = 31;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        LATCH = 3'd2,
        START = 3'd3,
        WAIT  = 3'd4,
        WRITE = 3'd5
    } schedState;
endpackage

// File: rtl/logbar_if.sv
// Spectrum RAM, converter and bar RAM connections of the log-bar scheduler.
interface logbar_if
    import logbar_pkg::*;
#(
    parameter int bw_addr = 5,
    parameter int bw_mag  = 17
);
    logic [bw_addr-1:0] MagAddr;
    logic               MagCh;
    logic [bw_mag-1:0]  MagData;
    logic               ConvStart;
    logic [bw_mag-1:0]  ConvIn;
    logic [BARW-1:0]    ConvOut;
    logic               ConvEnd;
    logic [bw_addr-1:0] BarAddr;
    logic               BarCh;
    logic               BarWe;
    logic [BARW-1:0]    BarWData;
    logic [BARW-1:0]    BarRData;

    modport master (
        output MagAddr, MagCh, ConvStart, ConvIn, BarAddr, BarCh, BarWe, BarWData,
        input  MagData, ConvOut, ConvEnd, BarRData
    );

    modport slave (
        input  MagAddr, MagCh, ConvStart, ConvIn, BarAddr, BarCh, BarWe, BarWData,
        output MagData, ConvOut, ConvEnd, BarRData
    );
endinterface

// File: rtl/logbar_hold.sv
// Fall-off merge: the previous bar decays by DECAY (floored at zero) and the
// new conversion wins whenever it is taller than the decayed bar.
module logbar_hold
    import logbar_pkg::*;
#(
    parameter logic [BARW-1:0] DECAY = BARW'(DECAY_DEF)
) (
    input  logic [BARW-1:0] oldVal,
    input  logic [BARW-1:0] newVal,
    output logic [BARW-1:0] mergedVal
);
    logic [BARW-1:0] held;

    // Decay with saturation at zero, then take the larger of the two heights.
    always_comb begin
        held      = {BARW{1'b0}};
        mergedVal = {BARW{1'b0}};
        if (oldVal > DECAY) begin
            held = oldVal - DECAY;
        end else begin
            held = {BARW{1'b0}};
        end
        if (newVal > held) begin
            mergedVal = newVal;
        end else begin
            mergedVal = held;
        end
    end
endmodule

// File: rtl/logbar_scheduler.sv
// Walks every bar of both channels once per frame through the shared log-bar
// converter and writes the decayed-and-merged heights into the bar RAM.
module logbar_scheduler
    import logbar_pkg::*;
#(
    parameter int NBAR    = NBAR_DEF,
    parameter int bw_addr = 5,
    parameter int bw_mag  = 17,
    parameter int DECAY   = DECAY_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic      Clock,
    input  logic      Reset,
    input  logic      FrameStart,
    output logic      Busy,
    output logic      Done,
    output logic      Err,
    logbar_if.master  bus
);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]      TMAX     = TW'(TIMEOUT);
    localparam logic [bw_addr-1:0] LAST_IDX = bw_addr'(NBAR - 1);

    schedState          state, stateNext;
    logic [bw_addr-1:0] idx, idxNext;
    logic               ch, chNext;
    logic [TW-1:0]      timer, timerNext;
    logic [bw_mag-1:0]  rMag;
    logic [BARW-1:0]    rOld;
    logic [BARW-1:0]    rWData;
    logic [BARW-1:0]    newVal;
    logic [BARW-1:0]    merged;
    logic               errNext;
    logic               doneNext;

    logbar_hold #(
        .DECAY (BARW'(DECAY))
    ) uHold (
        .oldVal    (rOld),
        .newVal    (newVal),
        .mergedVal (merged)
    );

    // Addresses come straight from the item registers, so they hold ADDR..WRITE.
    assign bus.MagAddr  = idx;
    assign bus.MagCh    = ch;
    assign bus.BarAddr  = idx;
    assign bus.BarCh    = ch;
    assign bus.ConvIn   = rMag;
    assign bus.BarWData = rWData;

    // FSM state register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state, item advance, timeout and the value handed to the merge.
    always_comb begin
        stateNext = state;
        idxNext   = idx;
        chNext    = ch;
        timerNext = timer;
        errNext   = Err;
        doneNext  = 1'b0;
        newVal    = {BARW{1'b0}};
        case (state)
            IDLE: begin
                if (FrameStart) begin
                    idxNext   = {bw_addr{1'b0}};
                    chNext    = 1'b0;
                    errNext   = 1'b0;
                    stateNext = ADDR;
                end else begin
                    stateNext = IDLE;
                end
            end
            ADDR:  stateNext = LATCH;
            LATCH: stateNext = START;
            START: begin
                timerNext = {TW{1'b0}};
                stateNext = WAIT;
            end
            WAIT: begin
                if (bus.ConvEnd) begin
                    newVal    = bus.ConvOut;
                    stateNext = WRITE;
                end else if (timer == TMAX) begin
                    newVal    = {BARW{1'b0}};
                    errNext   = 1'b1;
                    stateNext = WRITE;
                end else begin
                    timerNext = timer + TW'(1);
                end
            end
            WRITE: begin
                if (!ch) begin
                    chNext    = 1'b1;
                    stateNext = ADDR;
                end else if (idx == LAST_IDX) begin
                    chNext    = 1'b0;
                    idxNext   = {bw_addr{1'b0}};
                    doneNext  = 1'b1;
                    stateNext = IDLE;
                end else begin
                    chNext    = 1'b0;
                    idxNext   = idx + bw_addr'(1);
                    stateNext = ADDR;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Datapath registers and registered status/strobe outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            idx           <= {bw_addr{1'b0}};
            ch            <= 1'b0;
            timer         <= {TW{1'b0}};
            rMag          <= {bw_mag{1'b0}};
            rOld          <= {BARW{1'b0}};
            rWData        <= {BARW{1'b0}};
            Busy          <= 1'b0;
            Done          <= 1'b0;
            Err           <= 1'b0;
            bus.ConvStart <= 1'b0;
            bus.BarWe     <= 1'b0;
        end else begin
            idx           <= idxNext;
            ch            <= chNext;
            timer         <= timerNext;
            Err           <= errNext;
            Done          <= doneNext;
            Busy          <= (stateNext != IDLE);
            bus.ConvStart <= (stateNext == START);
            bus.BarWe     <= (stateNext == WRITE);
            if (state == LATCH) begin
                rMag <= bus.MagData;
                rOld <= bus.BarRData;
            end
            // Merge is registered on the WAIT->WRITE edge so BarWData is stable for the write.
            if ((state == WAIT) && (stateNext == WRITE)) begin
                rWData <= merged;
            end
        end
    end
endmodule

// File: tb/tb_logbar_scheduler.sv
// Directed self-checking bench for logbar_scheduler with RAM and converter models.
module tb_logbar_scheduler;
    import logbar_pkg::*;

    localparam int NB = 4;
    localparam int AW = 2;
    localparam int MW = 17;
    localparam int TO = 7;

    logic Clock      = 1'b0;
    logic Reset      = 1'b1;
    logic FrameStart = 1'b0;
    logic Busy, Done, Err;

    logbar_if #(.bw_addr(AW), .bw_mag(MW)) bus();

    logbar_scheduler #(
        .NBAR(NB), .bw_addr(AW), .bw_mag(MW), .DECAY(1), .TIMEOUT(TO)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .FrameStart (FrameStart),
        .Busy       (Busy),
        .Done       (Done),
        .Err        (Err),
        .bus        (bus)
    );

    // Standalone merge unit with a larger fall-off.
    logic [6:0] hOld = 7'd0, hNew = 7'd0, hOut;
    logbar_hold #(.DECAY(7'd3)) uHoldChk (.oldVal(hOld), .newVal(hNew), .mergedVal(hOut));

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // Spectrum and bar RAM models, 1-cycle read latency.
    typedef struct { int addr; int ch; int data; int cyc; } wrT;
    wrT wrLog[$];
    wrT wEntry;
    logic [MW-1:0] magMem [2][NB];
    logic [6:0]    barMem [2][NB];
    logic          loadReq = 1'b0;
    logic [6:0]    loadVal = 7'd0;

    always @(posedge Clock) begin
        bus.MagData  <= magMem[bus.MagCh][bus.MagAddr];
        bus.BarRData <= barMem[bus.BarCh][bus.BarAddr];
        if (loadReq) begin
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < NB; i++)
                    barMem[c][i] <= loadVal;
        end else if (bus.BarWe) begin
            barMem[bus.BarCh][bus.BarAddr] <= bus.BarWData;
            wEntry.addr = int'(bus.BarAddr);
            wEntry.ch   = int'(bus.BarCh);
            wEntry.data = int'(bus.BarWData);
            wEntry.cyc  = cyc;
            wrLog.push_back(wEntry);
        end
    end

    // Converter model: End three cycles after Start, result = operand[13:7].
    int         cvCnt = 0;
    logic [MW-1:0] cvOp = '0;
    logic       muteOn  = 1'b0;
    logic       spurEnd = 1'b0;

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cvCnt <= 0;
            cvOp  <= '0;
        end else if (bus.ConvStart) begin
            cvCnt <= 3;
            cvOp  <= bus.ConvIn;
        end else if (cvCnt != 0) begin
            cvCnt <= cvCnt - 1;
        end
    end

    assign bus.ConvEnd = ((cvCnt == 1) && !(muteOn && bus.BarAddr == 2'd2 && bus.BarCh == 1'b1)) || spurEnd;
    assign bus.ConvOut = cvOp[13:7];

    int nChecks = 0;
    int nErrors = 0;
    int startCyc = 0;
    int expW [2*NB];

    task automatic checkResult(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int convOf(int k);
        return (k * 13) + 3;
    endfunction

    function automatic logic [MW-1:0] magOf(int k);
        return MW'((convOf(k) << 7) | 'h35 | 'h10000);
    endfunction

    task automatic loadBars(input logic [6:0] v);
        loadVal = v;
        loadReq = 1'b1;
        @(negedge Clock);
        loadReq = 1'b0;
    endtask

    task automatic pulseStart();
        FrameStart = 1'b1;
        startCyc   = cyc;
        @(negedge Clock);
        FrameStart = 1'b0;
        checkResult("busyRise", Busy, 1);
    endtask

    task automatic waitDone(input string tag, input int expLat);
        int n = 0;
        while (!Done && n < 2000) begin
            @(negedge Clock);
            n++;
        end
        checkResult({tag, "_doneSeen"}, Done, 1);
        if (Done) checkResult({tag, "_latency"}, cyc - startCyc, expLat);
        checkResult({tag, "_busyAtDone"}, Busy, 0);
    endtask

    task automatic checkWrites(input string tag);
        checkResult({tag, "_count"}, wrLog.size(), 2*NB);
        for (int k = 0; k < 2*NB && k < wrLog.size(); k++) begin
            checkResult($sformatf("%s_w%0d_addr", tag, k), wrLog[k].addr, k / 2);
            checkResult($sformatf("%s_w%0d_ch", tag, k), wrLog[k].ch, k % 2);
            checkResult($sformatf("%s_w%0d_data", tag, k), wrLog[k].data, expW[k]);
        end
    endtask

    task automatic setPattern();
        for (int k = 0; k < 2*NB; k++) begin
            magMem[k % 2][k / 2] = magOf(k);
            expW[k] = convOf(k);
        end
    endtask

    task automatic setFlat(input int conv, input int wr);
        for (int k = 0; k < 2*NB; k++) begin
            magMem[k % 2][k / 2] = MW'(conv << 7);
            expW[k] = wr;
        end
    endtask

    int hv [6][3] = '{'{0, 10, 10}, '{2, 0, 0}, '{3, 0, 0}, '{4, 0, 1}, '{50, 10, 47}, '{5, 9, 9}};

    initial begin
        setPattern();
        loadBars(7'd0);
        @(negedge Clock);
        checkResult("rst_Busy", Busy, 0);
        checkResult("rst_Done", Done, 0);
        checkResult("rst_Err", Err, 0);
        checkResult("rst_ConvStart", bus.ConvStart, 0);
        checkResult("rst_BarWe", bus.BarWe, 0);
        checkResult("rst_MagAddr", bus.MagAddr, 0);
        checkResult("rst_BarWData", bus.BarWData, 0);
        checkResult("rst_ConvIn", bus.ConvIn, 0);
        Reset = 1'b0;
        @(negedge Clock);

        for (int v = 0; v < 6; v++) begin
            hOld = 7'(hv[v][0]);
            hNew = 7'(hv[v][1]);
            #1;
            checkResult($sformatf("hold3_v%0d", v), hOut, hv[v][2]);
        end
        @(negedge Clock);

        // Normal frame.
        wrLog.delete();
        pulseStart();
        waitDone("normal", 57);
        checkWrites("normal");
        if (wrLog.size() > 0) checkResult("normal_firstWrCyc", wrLog[0].cyc - startCyc, 7);
        checkResult("normal_err", Err, 0);
        @(negedge Clock);
        checkResult("normal_doneDrop", Done, 0);

        // Fall-off over two back-to-back frames, second started in the Done cycle.
        setFlat(10, 49);
        loadBars(7'd50);
        wrLog.delete();
        pulseStart();
        waitDone("fall1", 57);
        checkWrites("fall1");
        setFlat(10, 48);
        wrLog.delete();
        pulseStart();
        waitDone("fall2", 57);
        checkWrites("fall2");

        // Timeout on (2,R): held value written, Err sticky until next frame.
        @(negedge Clock);
        setFlat(10, 10);
        expW[5] = 4;
        loadBars(7'd5);
        muteOn = 1'b1;
        wrLog.delete();
        pulseStart();
        waitDone("tmo", 62);
        checkWrites("tmo");
        checkResult("tmo_errSticky", Err, 1);
        muteOn = 1'b0;
        setFlat(10, 10);
        wrLog.delete();
        pulseStart();
        checkResult("tmo_errCleared", Err, 0);
        waitDone("afterTmo", 57);
        checkWrites("afterTmo");

        // FrameStart while Busy is ignored.
        @(negedge Clock);
        setPattern();
        loadBars(7'd0);
        wrLog.delete();
        pulseStart();
        repeat (20) @(negedge Clock);
        FrameStart = 1'b1;
        @(negedge Clock);
        FrameStart = 1'b0;
        waitDone("busyStart", 57);
        checkWrites("busyStart");
        repeat (3) @(negedge Clock);
        checkResult("busyStart_noRestart", Busy, 0);

        // Reset during WAIT of (1,L).
        loadBars(7'd0);
        wrLog.delete();
        pulseStart();
        repeat (17) @(negedge Clock);
        checkResult("rstMid_preAddr", bus.MagAddr, 1);
        checkResult("rstMid_preBusy", Busy, 1);
        Reset = 1'b1;
        #1;
        checkResult("rstMid_Busy", Busy, 0);
        checkResult("rstMid_BarWe", bus.BarWe, 0);
        checkResult("rstMid_ConvStart", bus.ConvStart, 0);
        checkResult("rstMid_MagAddr", bus.MagAddr, 0);
        checkResult("rstMid_BarCh", bus.BarCh, 0);
        checkResult("rstMid_Done", Done, 0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        repeat (10) @(negedge Clock);
        checkResult("rstMid_writes", wrLog.size(), 2);
        wrLog.delete();
        pulseStart();
        waitDone("afterRst", 57);
        checkWrites("afterRst");

        // Spurious ConvEnd during ADDR and LATCH of item (0,L).
        @(negedge Clock);
        wrLog.delete();
        pulseStart();
        spurEnd = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        spurEnd = 1'b0;
        waitDone("spur", 57);
        checkWrites("spur");

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", nChecks, nErrors);
        $fatal(1);
    end
endmodule

// File: doc/logbar_scheduler.md
# logbar_scheduler

Sequences the single shared log-bar converter across both audio channels once per display frame. On each frame trigger it walks every bar index, left then right, reading the FFT magnitude from the spectrum RAM and running one conversion. It merges each result with the previous bar height using a fall-off (decay) rule and writes the bar RAM consumed by the display driver. It sits between the FFT magnitude buffer and the LED/display refresh logic.

## Interface
Parameters:
- NBAR, 32: bars per channel.
- bw_addr, 5: bar/magnitude address width; 2**bw_addr >= NBAR.
- bw_mag, 17: magnitude width; matches the converter input.
- DECAY, 1: per-frame fall-off in bar units; 0 disables fall-off.
- TIMEOUT, 31: maximum number of WAIT cycles allowed for a converter End.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-high.
- FrameStart  in  1  single-cycle frame trigger.
- Busy  out  1  high while a frame is in progress.
- Done  out  1  one-cycle pulse at frame end.
- Err  out  1  sticky converter-timeout flag.
- MagAddr  out  bw_addr  spectrum RAM read address.
- MagCh  out  1  spectrum RAM channel select; 0 = L, 1 = R.
- MagData  in  bw_mag  spectrum RAM data; synchronous, 1-cycle read latency.
- ConvStart  out  1  converter start pulse.
- ConvIn  out  bw_mag  converter operand, held stable from START until WRITE.
- ConvOut  in  7  converter result; valid in the cycle ConvEnd=1.
- ConvEnd  in  1  converter completion pulse.
- BarAddr  out  bw_addr  bar RAM address.
- BarCh  out  1  bar RAM channel select.
- BarWe  out  1  bar RAM write enable.
- BarWData  out  7  bar RAM write data.
- BarRData  in  7  bar RAM read data; 1-cycle read latency.

## Operation
- The FSM has six states: IDLE, ADDR, LATCH, START, WAIT, WRITE.
- IDLE:
  - A FrameStart pulse clears the index and channel to 0, clears Err, and moves to ADDR.
  - FrameStart received while Busy is ignored. There is no queue.
- ADDR: drives MagAddr/BarAddr = idx and MagCh/BarCh = ch; moves to LATCH.
- LATCH: captures MagData into rMag and BarRData into rOld; moves to START.
- START: ConvStart=1 for exactly one cycle; ConvIn = rMag; clears the timer; moves to WAIT.
- WAIT, per cycle:
  - If ConvEnd=1: rNew = ConvOut; go to WRITE.
  - Else if the timer equals TIMEOUT: rNew = 0, set Err; go to WRITE.
  - Otherwise increment the timer.
- WRITE:
  - Asserts BarWe=1 with BarWData = max(rNew, held), where held = (rOld > DECAY) ? rOld − DECAY : 0.
  - Advance order: ch 0 → 1 at the same idx; then ch = 0, idx + 1.
  - After idx = NBAR−1, ch = 1: return to IDLE and pulse Done. Otherwise go to ADDR.
- ConvEnd is ignored outside WAIT.
- Address and channel outputs hold their values from ADDR through WRITE.
- Reset mid-frame: every register clears immediately and the FSM enters IDLE. The converter shares Reset, so no stale End can arrive afterwards. No partial-frame recovery is performed.

## Timing
- Reset values: Busy=0, Done=0, Err=0, ConvStart=0, BarWe=0. All address, channel and data outputs are 0.
- Busy rises in the cycle after FrameStart is sampled.
- Busy falls in the same cycle Done=1, which is the cycle after the final WRITE.
- Per item: 4 cycles (ADDR, LATCH, START, WRITE) + W, where W = WAIT cycles (≥1, ≤ TIMEOUT+1).
- Frame latency: 2·NBAR·(4+W) + 1 cycles from FrameStart to Done.
- FrameStart in the Done cycle is accepted: the FSM is already in IDLE.
- Exactly one BarWe per (idx, ch) per frame.

## Structure
- Package logbar_pkg holds:
  - the FSM state enumeration;
  - the bar width constant (7);
  - the default NBAR, DECAY and TIMEOUT values, shared with the display driver.
- Sub-module logbar_hold: combinational decay-and-max merge (rOld, rNew, DECAY → BarWData). It is unit-testable in isolation.
- Timer width: $clog2(TIMEOUT+1).

## Test plan
- **Normal frame:** NBAR=4, DECAY=1; converter model returns MagData[13:7] after 3 cycles; bar RAM preloaded to 0. FrameStart → 8 writes in order (0,L) (0,R) … (3,R); BarWData equals the model output; Done pulses exactly 57 cycles after FrameStart.
- **Fall-off:** bar RAM preloaded to 50, converter returns 10. Frame 1 writes 49. Frame 2, with readback, writes 48. Preload 0 with DECAY=3 → write equals the converter value (no underflow).
- **Timeout:** converter model never asserts End for (2,R). After TIMEOUT+1 WAIT cycles: write held value, Err=1, frame completes. Next FrameStart clears Err.
- **FrameStart while Busy:** pulse FrameStart mid-frame → no restart, write count stays 8. FrameStart in the Done cycle → new frame starts the next cycle.
- **Reset mid-WAIT:** assert Reset during WAIT of (1,L) → all outputs at reset values immediately, no further writes. Next FrameStart restarts at (0,L).
- **Spurious ConvEnd:** inject ConvEnd during ADDR/LATCH → ignored; the item still waits for its own End.
